// File: rtl/spi_master_multi.sv
// spi_master_multi: parametrised SPI master, all CPOL/CPHA modes.
// Optional LSB-first support when SPI_LSB_FIRST_EN is defined.
module spi_master_multi #(
  parameter int DATA_W  = 8,
  parameter int NUM_SS  = 2,
  parameter int CLK_DIV = 4,
  parameter int SS_W    = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              err,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HALF_W = $clog2(2 * DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [SS_W-1:0]   ss_q, ss_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              rx_valid_q, rx_valid_d;
  logic              err_q, err_d;

  logic              lsb_in;
  logic              sel_ok;
  logic              div_end;
  logic              last_half;
  logic              lead;
  logic              sample;
  logic              try_start;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in = lsb_first;
`else
  assign lsb_in = 1'b0;
`endif

  assign sel_ok    = (32'(ss_sel) < 32'(NUM_SS));
  assign div_end   = (div_q == DIV_W'(CLK_DIV - 1));
  assign last_half = (half_q == HALF_W'(2 * DATA_W - 1));
  assign lead      = ~half_q[0];
  assign sample    = (lead != cpha_q);

  function automatic logic out_bit(
    input logic [DATA_W-1:0] v,
    input logic              lsb
  );
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] sh_out(
    input logic [DATA_W-1:0] v,
    input logic              lsb
  );
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [DATA_W-1:0] sh_in(
    input logic [DATA_W-1:0] v,
    input logic              b,
    input logic              lsb
  );
    return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction

  function automatic logic [NUM_SS-1:0] sel_dec(
    input logic [SS_W-1:0] s
  );
    logic [NUM_SS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (s == SS_W'(i)) m[i] = 1'b0;
    end
    return m;
  endfunction

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    half_d     = half_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rx_data_d  = rx_data_q;
    ss_d       = ss_q;
    ss_n_d     = ss_n_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    err_d      = 1'b0;
    try_start  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        sclk_d    = cpol_q;
        busy_d    = 1'b0;
        try_start = 1'b1;
      end
      S_SETUP: begin
        div_d = div_q + 1'b1;
        if (div_end) begin
          div_d   = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        div_d = div_q + 1'b1;
        if (div_end) begin
          div_d  = '0;
          half_d = half_q + 1'b1;
          sclk_d = ~sclk_q;
          if (sample) begin
            rx_d = sh_in(rx_q, miso, lsb_q);
          end else if (!last_half) begin
            mosi_d = out_bit(tx_q, lsb_q);
            tx_d   = sh_out(tx_q, lsb_q);
          end
          if (last_half) begin
            half_d  = '0;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        div_d = div_q + 1'b1;
        if (div_end) begin
          div_d      = '0;
          state_d    = S_DONE;
          ss_n_d     = '1;
          rx_data_d  = rx_q;
          rx_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        try_start = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ss_n_d  = '1;
        busy_d  = 1'b0;
      end
    endcase

    // The DONE cycle doubles as the cycle busy falls, so a held
    // start chains frames with a single ss_n-high cycle between.
    if (try_start && start) begin
      if (sel_ok) begin
        state_d = S_SETUP;
        ss_d    = ss_sel;
        cpol_d  = cpol;
        cpha_d  = cpha;
        lsb_d   = lsb_in;
        div_d   = '0;
        half_d  = '0;
        rx_d    = '0;
        busy_d  = 1'b1;
        sclk_d  = cpol;
        ss_n_d  = sel_dec(ss_sel);
        if (!cpha) begin
          mosi_d = out_bit(tx_data, lsb_in);
          tx_d   = sh_out(tx_data, lsb_in);
        end else begin
          tx_d   = tx_data;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State and registered outputs; reset drops every select at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      half_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_data_q  <= '0;
      ss_q       <= '0;
      ss_n_q     <= '1;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      half_q     <= half_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rx_data_q  <= rx_data_d;
      ss_q       <= ss_d;
      ss_n_q     <= ss_n_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign ss_n     = ss_n_q;

endmodule

// File: doc/spi_master_multi.md
Name: spi_master_multi

Overview:
Parametrised SPI master, the next generation of spi_master. Adds configurable frame width, slave-select count, SCLK divider and all four CPOL/CPHA modes. Uses a start/busy/rx_valid handshake so a host FSM or register block can issue single full-duplex frames to one of NUM_SS slaves.

Parameters:
DATA_W, 8, frame width in bits (2..32).
NUM_SS, 2, number of active-low slave-select outputs (1..16).
CLK_DIV, 4, clk cycles per SCLK half-period (>=1); SCLK = clk/(2*CLK_DIV).
SS_W, $clog2(NUM_SS) min 1, width of ss_sel (derived, do not override).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  request a frame; sampled only in IDLE
ss_sel  in  SS_W  target slave index, latched with start
cpol  in  1  SCLK idle level, latched with start
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; latched with start
tx_data  in  DATA_W  frame to transmit, latched with start
rx_data  out  DATA_W  last received frame; valid when rx_valid
rx_valid  out  1  one-cycle pulse, frame complete
busy  out  1  high from the cycle after an accepted start until end of DONE
err  out  1  one-cycle pulse, start rejected (ss_sel >= NUM_SS)
sclk  out  1  serial clock
mosi  out  1  serial data out, MSB first
miso  in  1  serial data in
ss_n  out  NUM_SS  slave selects, at most one low at a time

Behaviour:
- Reset (rst=0, async): state IDLE; sclk=0, mosi=0, ss_n all 1, busy=0, rx_valid=0, err=0, rx_data=0, counters cleared. Reset mid-frame aborts immediately and raises ss_n the same instant.
- IDLE: sclk driven to the last latched cpol (0 after reset). If start=1 and ss_sel<NUM_SS: latch tx_data, ss_sel, cpol, cpha; go to SETUP. If start=1 and ss_sel>=NUM_SS: err=1 for one cycle, stay in IDLE, busy stays 0.
- SETUP (CLK_DIV cycles): ss_n[ss_sel]=0, busy=1, sclk=cpol. If cpha=0, mosi=tx_data[DATA_W-1] from the first SETUP cycle.
- TRANSFER (2*DATA_W half-periods, each CLK_DIV cycles): sclk toggles at the end of each half-period.
  - cpha=0: sample miso on leading edges, shift mosi on trailing edges. The final trailing edge does not shift.
  - cpha=1: shift mosi on leading edges (the first leading edge presents the MSB), sample miso on trailing edges.
  - Sampled bits shift into the LSB of the rx shift register.
  - Bit counter counts 0..DATA_W-1 sample edges; on the DATA_W-th sample go to HOLD. sclk has returned to cpol by then.
- HOLD (CLK_DIV cycles): ss_n still low, sclk=cpol, mosi holds its last bit.
- DONE (1 cycle): ss_n all 1, rx_data<=shift register, rx_valid=1, busy=1. Next cycle busy=0 and state is IDLE.
- start while busy is ignored (no queueing, no err).
- A start in the cycle busy falls is accepted normally, giving back-to-back frames with ss_n high for at least 1 cycle.
- Latency: start accepted at cycle T; busy high T+1 through T+(2*DATA_W+2)*CLK_DIV+1; rx_valid at that final cycle. DATA_W=8, CLK_DIV=4 gives 73 busy cycles.
- cpol, cpha, ss_sel and tx_data changes while busy have no effect on the current frame.
- CLK_DIV=1 is legal: SCLK = clk/2.

Optional Feature:
Macro SPI_LSB_FIRST_EN.
- Defined: adds input port lsb_first (1 bit), latched with start. When 1, mosi sends tx_data[0] first and received bits enter at the MSB and shift right, so rx_data[0] is the first bit sampled.
- Not defined: port absent, MSB-first only. Timing is identical in both builds.

Test Plan:
1. Reset: hold rst=0 for 3 cycles mid-frame -> ss_n=2'b11, sclk=0, busy=0 immediately; no rx_valid after release.
2. Mode 0, DATA_W=8, CLK_DIV=4, ss_sel=0, tx_data=8'hA5, miso looped to mosi -> ss_n=2'b10 during frame, 8 rising sclk edges, mosi sequence 1,0,1,0,0,1,0,1, rx_data=8'hA5 with rx_valid 73 cycles after start.
3. Mode 3 (cpol=1, cpha=1), ss_sel=1, tx_data=8'h3C, slave model returns 8'hC3 -> sclk idles 1, ss_n=2'b01, mosi changes on falling edges, rx_data=8'hC3.
4. Modes 1 and 2 with tx_data=8'h81, loopback -> rx_data=8'h81 in both, sample edge matches mode.
5. start with ss_sel=2 (NUM_SS=2) -> err pulses 1 cycle, ss_n stays 2'b11, busy stays 0. start pulses while busy -> ignored, single rx_valid.
6. Back-to-back: start held high -> second frame begins with ss_n high exactly 1 cycle between frames. With SPI_LSB_FIRST_EN defined, lsb_first=1 and tx_data=8'h01 -> first mosi bit 1, loopback rx_data=8'h01.
